rr_grant_sched8: RTL and testbench
==================================

# rr_grant_sched8

Round-robin scheduler that shares one 8-way resource among eight requesters. It drives the select and enable inputs of the team's 3-to-8 line decoder: GNT_W[2:0] goes to the decoder's W2..W0 and GNT_EN goes to its EN. It also presents the equivalent one-hot GNT vector. Grants are registered, separated by one idle cycle, and bounded by a programmable hold limit.

## Interface
- MAX_HOLD, default 15: maximum consecutive grant cycles per requester. Range 0..255; 0 disables the limit.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  arbitration enable; when low, no new grant is issued.
- REQ  in  8  request lines; REQ[i] is held high by requester i for as long as it wants the resource.
- GNT_EN  out  1  a grant is active; drives the decoder enable.
- GNT_W  out  3  index of the granted requester; drives decoder W2..W0.
- GNT  out  8  one-hot grant; GNT[i] = GNT_EN && (GNT_W == i).
- TIMEOUT  out  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

## Operation
- State: FSM {IDLE, GRANT, GAP}; pointer PTR[2:0] holds the last granted index; 8-bit hold counter HCNT.
- Arbitration function (used in IDLE and GAP):
  - Search REQ starting at index PTR+1, mod 8, ascending with wrap.
  - The first set bit wins. The last index checked is PTR itself, so a lone requester can be re-granted.
- IDLE:
  - If EN=1 and REQ!=0: latch the winner into GNT_W and PTR, set GNT_EN=1, set HCNT=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Release condition A: REQ[GNT_W]=0.
  - Release condition B: MAX_HOLD!=0 and HCNT==MAX_HOLD.
  - On A or B: GNT_EN=0, go to GAP. When B occurs without A, TIMEOUT=1 for that GAP cycle.
  - Otherwise HCNT increments by 1; saturating is irrelevant because the count is bounded by MAX_HOLD.
  - EN is ignored in GRANT: an active grant runs to release.
- GAP:
  - Outputs GNT_EN=0 and GNT=0.
  - Arbitrates exactly as IDLE does. The winner goes to GRANT; with no eligible request, go to IDLE.
  - The just-released requester can win again only if no other request is pending, by virtue of the search order.
- GNT_W holds its last value while GNT_EN=0 (don't-care to the decoder, but stable). GNT is all zeros whenever GNT_EN=0.
- Reset values: state=IDLE, PTR=7 (so the first search starts at index 0), HCNT=0, GNT_EN=0, GNT_W=0, GNT=0, TIMEOUT=0.
- All outputs are registered; there is no combinational path from REQ or EN to any output.

## Timing
- Request-to-grant latency:
  - REQ sampled at edge k in IDLE → GNT_EN=1 after edge k.
  - Back-to-back grants always have exactly one GAP cycle between them.
- Grant length:
  - Equals the number of edges at which REQ[GNT_W] is sampled high while in GRANT, plus 1.
  - Capped at MAX_HOLD cycles.
  - MAX_HOLD=1 gives one-cycle grants with a TIMEOUT pulse whenever the requester is still asserting.
- Release: REQ[GNT_W] sampled low at edge k → GNT_EN=0 after edge k. GNT never shows two bits set and never switches index without a GAP cycle.
- Simultaneous drop and limit: if REQ[GNT_W] drops on the same edge HCNT reaches MAX_HOLD, the release is normal and TIMEOUT=0.
- EN falling in IDLE or GAP blocks arbitration from the next edge. EN rising in IDLE with REQ!=0 gives a grant one cycle later.
- Reset mid-grant: RST sampled high → all outputs 0 and PTR=7 after that edge; reset has priority over every other event.

## Test plan
- Reset, then REQ=8'h01, EN=1 → next cycle GNT_EN=1, GNT_W=0, GNT=8'h01, TIMEOUT=0.
- MAX_HOLD=4, REQ=8'hFF held, EN=1:
  - Grants visit indices 0,1,...,7,0, each for 4 cycles.
  - One GAP cycle between grants, with TIMEOUT=1 in each GAP cycle.
- Fairness:
  - Grant index 2.
  - REQ becomes 8'h85 and REQ[2] is then deasserted/reasserted each release.
  - Grant order is 7, 0, 2, 7 …, never 2 twice in a row while others are pending.
- Early release: grant to index 3, drop REQ[3] after 3 cycles high → GNT_EN=0 the next cycle, TIMEOUT stays 0, no other grant when REQ=0 (state IDLE).
- EN gating:
  - Drop EN mid-grant to index 5 with REQ=8'h60 → index 5 keeps its grant until REQ[5] falls, then no new grant while EN=0.
  - Raise EN → index 6 is granted one cycle later.
- Reset mid-grant: pulse RST during a grant to index 4 → outputs all 0 the next cycle. Then REQ=8'h81 → grant index 0 first, index 7 after it.

Source files
------------

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler sharing one 8-way resource among eight requesters.
// Drives a 3-to-8 decoder (GNT_W/GNT_EN) and a one-hot GNT, all registered.
module rr_grant_sched8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] REQ,
  output logic       GNT_EN,
  output logic [2:0] GNT_W,
  output logic [7:0] GNT,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic       HOLD_ON  = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic       gnt_en_d;
  logic [2:0] gnt_w_d;
  logic [7:0] gnt_d;
  logic       timeout_d;

  logic       win_valid;
  logic [2:0] win_idx;
  logic       rel_drop;
  logic       rel_limit;

  // Search starts at ptr+1 and wraps; ptr itself has the lowest priority so a
  // lone requester can be re-granted. Descending loop: nearest offset wins.
  function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {win_valid, win_idx} = rr_pick(REQ, ptr_q);
  end

  assign rel_drop  = ~REQ[GNT_W];
  assign rel_limit = HOLD_ON && (hcnt_q == HOLD_LIM);

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_en_d  = 1'b0;
    gnt_w_d   = GNT_W;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (EN && win_valid) begin
          state_d  = GRANT;
          ptr_d    = win_idx;
          gnt_w_d  = win_idx;
          gnt_en_d = 1'b1;
          hcnt_d   = 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // EN is deliberately ignored here: an active grant runs to release.
        if (rel_drop || rel_limit) begin
          state_d   = GAP;
          timeout_d = rel_limit && !rel_drop;
        end else begin
          gnt_en_d = 1'b1;
          hcnt_d   = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = gnt_en_d ? (8'd1 << gnt_w_d) : 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      hcnt_q  <= 8'd0;
      GNT_EN  <= 1'b0;
      GNT_W   <= 3'd0;
      GNT     <= 8'd0;
      TIMEOUT <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      GNT_EN  <= gnt_en_d;
      GNT_W   <= gnt_w_d;
      GNT     <= gnt_d;
      TIMEOUT <= timeout_d;
    end
  end

  // Structural invariants of the registered outputs.
  a_onehot : assert property (@(posedge CLK) $onehot0(GNT));
  a_gnt_en : assert property (@(posedge CLK) GNT_EN == (|GNT));
  a_to_gap : assert property (@(posedge CLK) !(TIMEOUT && GNT_EN));

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Directed bench for rr_grant_sched8: three instances (hold limits 4, 15, 1)
// share one stimulus; each scenario checks the instance it targets.
module tb_rr_grant_sched8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic [7:0] REQ = 8'h00;

  logic       a_gnt_en, b_gnt_en, c_gnt_en;
  logic [2:0] a_gnt_w,  b_gnt_w,  c_gnt_w;
  logic [7:0] a_gnt,    b_gnt,    c_gnt;
  logic       a_to,     b_to,     c_to;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  rr_grant_sched8 #(.MAX_HOLD(4)) dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
    .GNT_EN(a_gnt_en), .GNT_W(a_gnt_w), .GNT(a_gnt), .TIMEOUT(a_to)
  );

  rr_grant_sched8 dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
    .GNT_EN(b_gnt_en), .GNT_W(b_gnt_w), .GNT(b_gnt), .TIMEOUT(b_to)
  );

  rr_grant_sched8 #(.MAX_HOLD(1)) dut_c (
    .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
    .GNT_EN(c_gnt_en), .GNT_W(c_gnt_w), .GNT(c_gnt), .TIMEOUT(c_to)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then read 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b0;
    REQ = 8'h00;
    step();
    RST = 1'b0;
  endtask

  task automatic chk_b(input string tag, input logic en, input logic [2:0] w,
                       input logic to);
    check({tag, ".en"}, 32'(b_gnt_en), 32'(en));
    check({tag, ".w"},  32'(b_gnt_w),  32'(w));
    check({tag, ".gnt"}, 32'(b_gnt), en ? 32'(8'd1 << w) : 32'd0);
    check({tag, ".to"}, 32'(b_to), 32'(to));
  endtask

  initial begin
    // Reset state and first grant.
    step();
    chk_b("rst", 1'b0, 3'd0, 1'b0);
    RST = 1'b0; REQ = 8'h01; EN = 1'b1;
    step();
    chk_b("first", 1'b1, 3'd0, 1'b0);

    // Rotation through all indices with MAX_HOLD=4 and TIMEOUT in each gap.
    do_reset();
    REQ = 8'hFF; EN = 1'b1;
    step();
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("rot%0d.c%0d.en", g, c), 32'(a_gnt_en), 32'd1);
        check($sformatf("rot%0d.c%0d.gnt", g, c), 32'(a_gnt),
              32'(8'd1 << (g % 8)));
        check($sformatf("rot%0d.c%0d.to", g, c), 32'(a_to), 32'd0);
        step();
      end
      check($sformatf("rot%0d.gap.en", g), 32'(a_gnt_en), 32'd0);
      check($sformatf("rot%0d.gap.gnt", g), 32'(a_gnt), 32'd0);
      check($sformatf("rot%0d.gap.to", g), 32'(a_to), 32'd1);
      check($sformatf("rot%0d.gap.w", g), 32'(a_gnt_w), 32'(g % 8));
      step();
    end

    // Drop on the same edge the limit is reached: normal release.
    do_reset();
    REQ = 8'h01; EN = 1'b1;
    step(); step(); step(); step();
    check("sim.hold4.en", 32'(a_gnt_en), 32'd1);
    REQ = 8'h00;
    step();
    check("sim.rel.en", 32'(a_gnt_en), 32'd0);
    check("sim.rel.to", 32'(a_to), 32'd0);

    // MAX_HOLD=1: single-cycle grants, TIMEOUT while still requesting.
    do_reset();
    REQ = 8'h03; EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("h1.%0d.en", k), 32'(c_gnt_en), 32'd1);
      check($sformatf("h1.%0d.gnt", k), 32'(c_gnt), 32'(8'd1 << (k % 2)));
      step();
      check($sformatf("h1.%0d.gap.en", k), 32'(c_gnt_en), 32'd0);
      check($sformatf("h1.%0d.gap.to", k), 32'(c_to), 32'd1);
    end

    // Fairness: released requester yields to others still pending.
    do_reset();
    REQ = 8'h04; EN = 1'b1;
    step();
    chk_b("fair.start", 1'b1, 3'd2, 1'b0);
    REQ = 8'h85;
    step();
    chk_b("fair.hold", 1'b1, 3'd2, 1'b0);
    begin
      logic [2:0] seq [6] = '{3'd7, 3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
      logic [2:0] cur;
      cur = 3'd2;
      for (int k = 0; k < 6; k++) begin
        REQ = 8'h85 & ~(8'd1 << cur);
        step();
        chk_b($sformatf("fair%0d.gap", k), 1'b0, cur, 1'b0);
        REQ = 8'h85;
        step();
        chk_b($sformatf("fair%0d.gnt", k), 1'b1, seq[k], 1'b0);
        cur = seq[k];
      end
    end

    // Early release after three sampled-high cycles, then back to IDLE.
    do_reset();
    REQ = 8'h08; EN = 1'b1;
    step();
    chk_b("early.c1", 1'b1, 3'd3, 1'b0);
    step();
    chk_b("early.c2", 1'b1, 3'd3, 1'b0);
    step();
    chk_b("early.c3", 1'b1, 3'd3, 1'b0);
    REQ = 8'h00;
    step();
    chk_b("early.rel", 1'b0, 3'd3, 1'b0);
    step();
    chk_b("early.idle1", 1'b0, 3'd3, 1'b0);
    step();
    chk_b("early.idle2", 1'b0, 3'd3, 1'b0);

    // EN gating: grant runs to release, then nothing until EN rises.
    do_reset();
    REQ = 8'h20; EN = 1'b1;
    step();
    chk_b("en.gnt5", 1'b1, 3'd5, 1'b0);
    REQ = 8'h60; EN = 1'b0;
    step();
    chk_b("en.keep1", 1'b1, 3'd5, 1'b0);
    step();
    chk_b("en.keep2", 1'b1, 3'd5, 1'b0);
    REQ = 8'h40;
    step();
    chk_b("en.gap", 1'b0, 3'd5, 1'b0);
    step();
    chk_b("en.blk1", 1'b0, 3'd5, 1'b0);
    step();
    chk_b("en.blk2", 1'b0, 3'd5, 1'b0);
    EN = 1'b1;
    step();
    chk_b("en.gnt6", 1'b1, 3'd6, 1'b0);

    // Reset mid-grant, then pointer restarts the search at index 0.
    do_reset();
    REQ = 8'h10; EN = 1'b1;
    step();
    chk_b("rmid.gnt4", 1'b1, 3'd4, 1'b0);
    step();
    RST = 1'b1;
    step();
    chk_b("rmid.rst", 1'b0, 3'd0, 1'b0);
    RST = 1'b0; REQ = 8'h81;
    step();
    chk_b("rmid.gnt0", 1'b1, 3'd0, 1'b0);
    REQ = 8'h80;
    step();
    chk_b("rmid.gap", 1'b0, 3'd0, 1'b0);
    REQ = 8'h81;
    step();
    chk_b("rmid.gnt7", 1'b1, 3'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
